// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//
// Sends one command byte per request to the device over the shared open-drain
// PS/2 clock/data pads. The frame is a start bit, eight data bits LSB first,
// an odd parity bit and a stop bit. The transmitter then checks the device
// ACK bit. Each accepted command ends in exactly one of done, ack_err or
// timeout.
//
// Ports:
//   clk          system clock; all logic runs on posedge clk
//   clrn         synchronous active-low reset
//   ps2_clk      raw PS/2 clock pad level
//   ps2_data     raw PS/2 data pad level
//   ps2_clk_oe   1 = pull the PS/2 clock low
//   ps2_data_oe  1 = pull the PS/2 data low
//   tx_data      command byte
//   tx_valid     command request; the byte is taken when tx_valid & tx_ready
//   tx_ready     high only while idle
//   busy         ~tx_ready
//   done         one-cycle pulse: frame sent and ACK seen
//   ack_err      one-cycle pulse: ACK slot sampled high (NACK)
//   timeout      one-cycle pulse: frame aborted because the device stopped clocking
//
// Optional build macro PS2_TX_RETRY_EN: when it is defined, a NACK or timeout
// re-sends the latched byte once from INHIBIT. A failure status is only
// reported if the retry also fails.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a command, both lines released
// INHIBIT   | clock held low for INHIBIT_CYCLES cycles
// REQ       | clock and data both low for one cycle (request-to-send, start bit)
// SEND      | clock released; drive frame bit k-1 on device fall k (k = 1..10)
// ACK       | both lines released; sample data on the next device fall
// WAIT_IDLE | wait for clock and data high, then report the status

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       clk_sync;
  logic [1:0]       data_sync;
  logic [9:0]       frame_q;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             data_q;
  logic             nack_q;
  logic             fall, clk_s, data_s;
  logic             tmo_active, tmo_hit;
  logic             accept, reload_inh;
  logic             fail_nack, fail_tmo;
`ifdef PS2_TX_RETRY_EN
  logic             retry_q;
`endif

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign accept = tx_valid & tx_ready;

  // The timeout counter counts down from TIMEOUT_CYCLES-1, so it reaches zero
  // TIMEOUT_CYCLES cycles after the last reload. A fall in that same cycle
  // takes priority and reloads the counter.
  assign tmo_active = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign tmo_hit    = tmo_active && (tmo_cnt == '0) && !fall;

  always_comb begin
    state_nxt   = state;
    tx_ready    = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done        = 1'b0;
    ack_err     = 1'b0;
    timeout     = 1'b0;
    fail_nack   = 1'b0;
    fail_tmo    = 1'b0;
    reload_inh  = 1'b0;
    case (state)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          reload_inh = 1'b1;
          state_nxt  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == '0) state_nxt = S_REQ;
      end
      S_REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        state_nxt   = S_SEND;
      end
      S_SEND: begin
        // Release data in the abort cycle itself, not one cycle later.
        ps2_data_oe = data_q & ~tmo_hit;
        if (tmo_hit) fail_tmo = 1'b1;
        else if (fall && bit_cnt == 4'd9) state_nxt = S_ACK;
      end
      S_ACK: begin
        if (tmo_hit) fail_tmo = 1'b1;
        else if (fall) state_nxt = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (tmo_hit) fail_tmo = 1'b1;
        else if (clk_s && data_s) begin
          if (nack_q) fail_nack = 1'b1;
          else begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (fail_nack || fail_tmo) begin
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        reload_inh = 1'b1;
        state_nxt  = S_INHIBIT;
      end else begin
        ack_err   = fail_nack;
        timeout   = fail_tmo;
        state_nxt = S_IDLE;
      end
`else
      ack_err   = fail_nack;
      timeout   = fail_tmo;
      state_nxt = S_IDLE;
`endif
    end
    busy = ~tx_ready;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= S_IDLE;
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
      frame_q   <= '0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      tmo_cnt   <= '0;
      data_q    <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};

      // The frame is kept whole rather than shifted so that a retry can re-send it.
      if (accept) frame_q <= {1'b1, ~^tx_data, tx_data};

      if (reload_inh) inh_cnt <= INH_LOAD;
      else if (state == S_INHIBIT && inh_cnt != '0) inh_cnt <= inh_cnt - INH_W'(1);

      if (state == S_REQ || (tmo_active && fall)) tmo_cnt <= TMO_LOAD;
      else if (tmo_active && tmo_cnt != '0) tmo_cnt <= tmo_cnt - TMO_W'(1);

      if (state == S_REQ) begin
        bit_cnt <= '0;
        data_q  <= 1'b1;
      end else if (state == S_SEND && fall) begin
        bit_cnt <= bit_cnt + 4'd1;
        data_q  <= ~frame_q[bit_cnt];
      end

      if (state == S_ACK && fall) nack_q <= data_s;
    end
  end

`ifdef PS2_TX_RETRY_EN
  always_ff @(posedge clk) begin
    if (!clrn)           retry_q <= 1'b0;
    else if (accept)     retry_q <= 1'b0;
    else if (reload_inh) retry_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  localparam int INH = 8;
  localparam int TMO = 100;
  localparam int H   = 6;    // device half-period in clk cycles
  localparam int PER = 10;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_pad, ps2_data_pad;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_err, timeout;

  int  n_tests = 0;
  int  n_fail = 0;
  int  n_done = 0, n_err = 0, n_tmo = 0;
  time tmo_time = 0, fall_time = 0;
  logic tmo_clk_oe = 1'b0, tmo_data_oe = 1'b0;

  assign ps2_clk_pad  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_pad = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk_pad), .ps2_data(ps2_data_pad),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .done(done), .ack_err(ack_err), .timeout(timeout)
  );

  always #(PER/2) clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done = n_done + 1;
    if (ack_err) n_err = n_err + 1;
    if (timeout) begin
      n_tmo = n_tmo + 1;
      tmo_time = $time;
      tmo_clk_oe = ps2_clk_oe;
      tmo_data_oe = ps2_data_oe;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side of one host-to-device frame. bits[0] is the start bit and
  // bits[k] the level read after fall k. nfalls < 10 abandons the frame.
  task automatic device_frame(input int nfalls, input logic ack_low,
                              output logic [10:0] bits, output int oe_len, output int data_idx);
    int n;
    bits = '1;
    oe_len = 0;
    data_idx = -1;
    n = 0;
    while (!ps2_clk_oe && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("inhibit seen", ps2_clk_oe, 1'b1);
    while (ps2_clk_oe && oe_len < 200) begin
      if (ps2_data_oe && data_idx < 0) data_idx = oe_len;
      oe_len++;
      @(negedge clk);
    end
    repeat (H) @(negedge clk);
    bits[0] = ps2_data_pad;
    for (int k = 1; k <= nfalls; k++) begin
      dev_clk = 1'b0;
      fall_time = $time;
      repeat (H) @(negedge clk);
      if (k <= 10) bits[k] = ps2_data_pad;
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    if (nfalls == 10) begin
      dev_data = ~ack_low;
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, tx_ready, 1'b1);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        nack;
    logic [10:0] exp_bits;   // {stop, parity, data, start}
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [10:0] bits;
    int oe_len, didx;
    int d0, e0, t0, n;

    vecs[0] = '{8'hED, 1'b0, 11'b1_1_11101101_0, 1, 0};
    vecs[1] = '{8'h00, 1'b0, 11'b1_1_00000000_0, 1, 0};
    vecs[2] = '{8'h01, 1'b0, 11'b1_0_00000001_0, 1, 0};
`ifdef PS2_TX_RETRY_EN
    vecs[3] = '{8'hFF, 1'b1, 11'b1_1_11111111_0, 1, 0};
`else
    vecs[3] = '{8'hFF, 1'b1, 11'b1_1_11111111_0, 0, 1};
`endif

    repeat (3) @(negedge clk);
    check("rst clk_oe", ps2_clk_oe, 1'b0);
    check("rst data_oe", ps2_data_oe, 1'b0);
    check("rst tx_ready", tx_ready, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst status", {done, ack_err, timeout}, 3'b000);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      d0 = n_done; e0 = n_err; t0 = n_tmo;
      start_cmd(vecs[i].data);
      check($sformatf("v%0d busy", i), busy, 1'b1);
      device_frame(10, ~vecs[i].nack, bits, oe_len, didx);
      check($sformatf("v%0d clk_oe len", i), oe_len, INH + 1);
      check($sformatf("v%0d data_oe idx", i), didx, INH);
      check($sformatf("v%0d bits", i), bits, vecs[i].exp_bits);
`ifdef PS2_TX_RETRY_EN
      if (vecs[i].nack) begin
        device_frame(10, 1'b1, bits, oe_len, didx);
        check($sformatf("v%0d retry clk_oe len", i), oe_len, INH + 1);
        check($sformatf("v%0d retry bits", i), bits, vecs[i].exp_bits);
      end
`endif
      wait_ready($sformatf("v%0d ready", i));
      check($sformatf("v%0d done cnt", i), n_done - d0, vecs[i].exp_done);
      check($sformatf("v%0d ack_err cnt", i), n_err - e0, vecs[i].exp_err);
      check($sformatf("v%0d timeout cnt", i), n_tmo - t0, 0);
    end

    // Timeout: the device stops clocking after fall 4 of a 0x00 frame.
    d0 = n_done; e0 = n_err; t0 = n_tmo;
    start_cmd(8'h00);
`ifdef PS2_TX_RETRY_EN
    device_frame(4, 1'b1, bits, oe_len, didx);
`endif
    device_frame(4, 1'b1, bits, oe_len, didx);
    check("tmo data_oe before", ps2_data_oe, 1'b1);
    n = 0;
    while (n_tmo == t0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tmo pulse seen", n_tmo - t0, 1);
    check("tmo latency", tmo_time - fall_time, (TMO + 2) * PER);
    check("tmo clk_oe at pulse", tmo_clk_oe, 1'b0);
    check("tmo data_oe at pulse", tmo_data_oe, 1'b0);
    @(negedge clk);
    check("tmo ready next", tx_ready, 1'b1);
    check("tmo other status", (n_done - d0) + (n_err - e0), 0);

    // Backpressure: 0x55 is presented during the 0xF4 frame.
    d0 = n_done; e0 = n_err;
    @(negedge clk);
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h55;
    device_frame(10, 1'b1, bits, oe_len, didx);
    check("bp first bits", bits, 11'b1_0_11110100_0);
    n = 0;
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("bp ready after first", tx_ready, 1'b1);
    check("bp done before accept", n_done - d0, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    device_frame(10, 1'b1, bits, oe_len, didx);
    check("bp second clk_oe len", oe_len, INH + 1);
    check("bp second bits", bits, 11'b1_1_01010101_0);
    wait_ready("bp ready end");
    check("bp done cnt", n_done - d0, 2);
    check("bp ack_err cnt", n_err - e0, 0);

    // Reset while the data line is being driven low during SEND.
    d0 = n_done; e0 = n_err; t0 = n_tmo;
    start_cmd(8'h00);
    device_frame(3, 1'b1, bits, oe_len, didx);
    check("mid data_oe driven", ps2_data_oe, 1'b1);
    clrn = 1'b0;
    @(negedge clk);
    check("mid rst clk_oe", ps2_clk_oe, 1'b0);
    check("mid rst data_oe", ps2_data_oe, 1'b0);
    check("mid rst tx_ready", tx_ready, 1'b1);
    check("mid rst busy", busy, 1'b0);
    clrn = 1'b1;
    repeat (TMO + 30) @(negedge clk);
    check("mid rst no status", (n_done - d0) + (n_err - e0) + (n_tmo - t0), 0);
    check("mid rst idle", tx_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter.
- Sends one command byte at a time (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared open-drain PS/2 clock and data lines.
- Pairs with the existing keyboard receiver on the same pads: the receiver decodes device-to-host frames; this block drives host-to-device frames and checks the device ACK.
- Indicates done, NACK or timeout for each command.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the PS/2 clock is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum clk cycles between consecutive device falling edges (15 ms at 50 MHz) before abort.

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- clrn  in  1  reset; synchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock pad level.
- ps2_data  in  1  raw PS/2 data pad level.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low; 0 = release.
- ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
- tx_data  in  8  command byte.
- tx_valid  in  1  command request.
- tx_ready  out  1  high only in IDLE; byte accepted when tx_valid & tx_ready.
- busy  out  1  ~tx_ready.
- done  out  1  one-cycle pulse: frame sent, device ACK seen.
- ack_err  out  1  one-cycle pulse: ACK slot sampled high (NACK).
- timeout  out  1  one-cycle pulse: frame aborted on timeout.

Behaviour:
- Input sync and edge detect:
  - ps2_clk passes through a 3-flop synchronizer.
  - fall = sync[2] & ~sync[1].
  - ps2_data passes through a 2-flop synchronizer.
- Reset (clrn=0 at posedge clk):
  - state=IDLE; ps2_clk_oe=0, ps2_data_oe=0; tx_ready=1, busy=0; done=ack_err=timeout=0; all counters cleared.
  - Reset mid-frame releases both lines on that edge and discards the frame; no status pulse.
- Frame: shift register = {stop=1, parity=~^tx_data, tx_data}. Data goes LSB first. Odd parity.
- States:
  - IDLE: tx_ready=1. On accept, latch the frame and go to INHIBIT next cycle. tx_valid while not IDLE is ignored.
  - INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: one cycle with ps2_clk_oe=1 and ps2_data_oe=1 (start bit 0), then go to SEND. ps2_clk_oe is held high for INHIBIT_CYCLES+1 cycles in total.
  - SEND: ps2_clk_oe=0.
    - ps2_data_oe stays 1 until the first fall.
    - On fall k (k=1..10), drive frame bit k-1: ps2_data_oe = ~bit.
    - Falls 1..8 drive data, 9 drives parity, 10 drives stop (release).
    - A 4-bit counter tracks falls. At fall 10, go to ACK.
  - ACK: both lines released. On the next fall, sample synchronized data: 0 = ACK, 1 = NACK. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized clock and data are both 1. Then pulse done (ACK) or ack_err (NACK) for one cycle and go to IDLE.
- Timeout:
  - A counter restarts on entry to SEND and on every fall.
  - It is active in SEND, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: release both lines, pulse timeout, go to IDLE. Exactly one of done/ack_err/timeout is pulsed per accepted command.
- Simultaneity:
  - A fall coinciding with the timeout terminal count takes the fall (counter restarts).
  - Accept in IDLE on the same cycle as a status pulse is impossible: the pulse is issued while leaving WAIT_IDLE, and tx_ready rises on the following cycle.
- Counter widths are sized by $clog2 of the parameters and saturate at terminal count; no wrap.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined:
  - On NACK or timeout, the latched byte is re-sent once, automatically, from INHIBIT.
  - ack_err/timeout pulse only if the retry also fails.
  - done pulses if the retry succeeds.
  - A 1-bit retry flag clears on accept.
- Undefined: no retry; first failure pulses immediately. Logic is absent.

Test Plan:
- Reset: hold clrn=0 during SEND with lines driven -> next edge ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, no status pulse.
- Send 0xED, INHIBIT_CYCLES=8, device model ACKs:
  - ps2_clk_oe high 9 cycles, ps2_data_oe rises in last.
  - Device samples start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - ACK driven low -> single done pulse, tx_ready back to 1.
- Send 0x00 -> parity bit 1. Send 0x01 -> parity bit 0. Both ACK -> done each.
- NACK: device leaves data high in ACK slot for 0xFF -> ack_err pulse, no done.
  - With PS2_TX_RETRY_EN: a second full INHIBIT+frame is observed. Device ACKs the second frame -> done only.
- Timeout: TIMEOUT_CYCLES=100; device stops clocking after 4 falls -> timeout pulse 100 cycles after fall 4, both oe=0, IDLE.
- Backpressure: tx_valid=1 held with new byte 0x55 during a 0xF4 frame -> ignored. 0x55 is accepted only after done, and its frame follows.
